spi_wb_bridge: RTL and testbench

- SPI slave (mode 0) that acts as a Wishbone master, so an external host can read and write any bus slave (bram, uart0, timer, gpio, everloop, pwm, ...).
- It is the other end of the SPI link that wb_spi drives as a master.
- Attaches to a spare master port of conbus, alongside the lm32 instruction and data masters.
- One bus transaction per chip-select frame. 32-bit address and data, MSB first.

---
 rtl/spi_wb_pkg.sv | 28 ++
 rtl/spi_wb_bridge_if.sv | 23 ++
 rtl/spi_wb_sync.sv | 37 +++
 rtl/spi_wb_bridge.sv | 166 ++++++++++++++++
 tb/tb_spi_wb_bridge.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/spi_wb_pkg.sv
// Shared definitions for the SPI-slave to Wishbone-master bridge.
//   state_t   : frame FSM encoding
//   wb_req_t  : bus request captured from the SPI frame, launched one clk later
//   *_BITS    : phase lengths in sck rising edges
package spi_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_TURN, ST_RDATA, ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } wb_req_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_BITS      = 8;
  localparam int ADDR_BITS     = 32;
  localparam int TURN_BITS     = 8;
  localparam int DATA_BITS     = 32;

  // Bit-counter value on the last rise of a phase of n bits.
  function automatic logic [5:0] last_bit(input int n);
    return 6'(n - 1);
  endfunction

endpackage

// File: rtl/spi_wb_bridge_if.sv
// Wishbone bus bundle between the bridge (master) and conbus (slave side).
//   wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o : master -> slave
//   wb_dat_i/wb_ack_i                                      : slave -> master
interface spi_wb_bridge_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/spi_wb_sync.sv
// Brings the asynchronous SPI pins into the clk domain.
//   in : clk, reset, spi_sck, spi_cs_n, spi_mosi
//   out: sck_rise / sck_fall (one-clk strobes), cs_n_s, mosi_s (synchronised)
// sck gets a third flop so edges are detected on already-synchronised values.
module spi_wb_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_n_s,
  output logic mosi_s
);
  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q  <= '0;
      cs_q   <= 2'b11;   // deselected while in reset
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_n_s   = cs_q[1];
  // mosi has the same latency as sck, so it is stable when the rise is seen.
  assign mosi_s   = mosi_q[1];
endmodule

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave acting as a Wishbone master: one bus transaction per
// chip-select frame (CMD, ADDR, then WDATA or TURN+RDATA), MSB first.
//   clk, reset          : system clock, synchronous active-high reset
//   spi_sck/cs_n/mosi   : host SPI inputs (asynchronous)
//   spi_miso            : read data to host, 0 outside RDATA
//   wb                  : Wishbone master port
//   busy                : bus cycle outstanding (= cyc)
//   err                 : one-clk pulse on ack timeout or rejected frame
module spi_wb_bridge
  import spi_wb_pkg::*;
#(
  parameter int          ack_timeout  = 64,
  parameter logic [31:0] timeout_data = 32'hFFFF_FFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_wb_bridge_if.master wb,
  output logic busy,
  output logic err
);
  localparam logic [15:0] TMO_LAST = 16'(ack_timeout - 1);

  logic        sck_rise, sck_fall, cs_n_s, mosi_s;
  state_t      state;
  logic [5:0]  bit_cnt;
  logic [31:0] sh_in, sh_next, rd_data, rd_shift;
  logic        is_write, rd_load, launch;
  wb_req_t     req;
  logic [15:0] tmo_cnt;

  spi_wb_sync u_sync (
    .clk, .reset, .spi_sck, .spi_cs_n, .spi_mosi,
    .sck_rise, .sck_fall, .cs_n_s, .mosi_s
  );

  assign sh_next  = {sh_in[30:0], mosi_s};
  assign busy     = wb.wb_cyc_o;
  assign spi_miso = (state == ST_RDATA) & rd_shift[31];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      sh_in       <= '0;
      rd_data     <= '0;
      rd_shift    <= '0;
      is_write    <= 1'b0;
      rd_load     <= 1'b0;
      launch      <= 1'b0;
      req         <= '0;
      tmo_cnt     <= '0;
      err         <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
    end else begin
      err    <= 1'b0;
      launch <= 1'b0;

      // Wishbone master: an outstanding cycle always runs to ack or timeout,
      // independent of what the frame FSM does.
      if (wb.wb_cyc_o) begin
        if (wb.wb_ack_i) begin
          wb.wb_cyc_o <= 1'b0;
          wb.wb_stb_o <= 1'b0;
          wb.wb_we_o  <= 1'b0;
          if (!wb.wb_we_o) rd_data <= wb.wb_dat_i;
        end else if (tmo_cnt == TMO_LAST) begin
          wb.wb_cyc_o <= 1'b0;
          wb.wb_stb_o <= 1'b0;
          wb.wb_we_o  <= 1'b0;
          rd_data     <= timeout_data;
          err         <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end else if (launch && !cs_n_s) begin
        // A frame torn down by cs_n before this clk never reaches the bus.
        wb.wb_adr_o <= req.adr;
        wb.wb_dat_o <= req.dat;
        wb.wb_we_o  <= req.we;
        wb.wb_sel_o <= 4'hF;
        wb.wb_cyc_o <= 1'b1;
        wb.wb_stb_o <= 1'b1;
        tmo_cnt     <= '0;
      end

      // Frame FSM
      if (cs_n_s && state != ST_IDLE) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: if (!cs_n_s) begin
            bit_cnt <= '0;
            if (wb.wb_cyc_o) begin
              state <= ST_DONE;
              err   <= 1'b1;
            end else begin
              state <= ST_CMD;
            end
          end
          ST_CMD: if (sck_rise) begin
            sh_in <= sh_next;
            if (bit_cnt == last_bit(CMD_BITS)) begin
              is_write <= sh_next[CMD_WRITE_BIT];
              state    <= ST_ADDR;
              bit_cnt  <= '0;
            end else bit_cnt <= bit_cnt + 6'd1;
          end
          ST_ADDR: if (sck_rise) begin
            sh_in <= sh_next;
            if (bit_cnt == last_bit(ADDR_BITS)) begin
              req.adr <= sh_next;
              bit_cnt <= '0;
              if (is_write) state <= ST_WDATA;
              else begin
                state  <= ST_TURN;
                req.we <= 1'b0;
                launch <= 1'b1;
              end
            end else bit_cnt <= bit_cnt + 6'd1;
          end
          ST_WDATA: if (sck_rise) begin
            sh_in <= sh_next;
            if (bit_cnt == last_bit(DATA_BITS)) begin
              req.dat <= sh_next;
              req.we  <= 1'b1;
              launch  <= 1'b1;
              state   <= ST_DONE;
              bit_cnt <= '0;
            end else bit_cnt <= bit_cnt + 6'd1;
          end
          ST_TURN: if (sck_rise) begin
            if (bit_cnt == last_bit(TURN_BITS)) begin
              state   <= ST_RDATA;
              bit_cnt <= '0;
              rd_load <= 1'b1;
            end else bit_cnt <= bit_cnt + 6'd1;
          end
          ST_RDATA: begin
            // First fall loads the read word, later falls shift it out.
            if (sck_fall) begin
              rd_shift <= rd_load ? rd_data : {rd_shift[30:0], 1'b0};
              rd_load  <= 1'b0;
            end
            if (sck_rise) begin
              if (bit_cnt == last_bit(DATA_BITS)) begin
                state   <= ST_DONE;
                bit_cnt <= '0;
              end else bit_cnt <= bit_cnt + 6'd1;
            end
          end
          default: ;  // ST_DONE: wait for cs_n to rise
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_wb_bridge.sv
module tb_spi_wb_bridge;
  import spi_wb_pkg::*;

  localparam int HALF = 4;  // sck half period in clk cycles (sck = clk/8)

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, busy, err;

  spi_wb_bridge_if bus();

  spi_wb_bridge dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .wb(bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  exp_t sb[$];
  int ack_delay = 3;            // clk cycles until ack, -1 = never
  logic [31:0] slave_rdata = '0;
  int cyc_starts = 0, cyc_len = 0, err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wishbone slave model plus bus/err monitor, evaluated on falling edges.
  initial begin
    logic cyc_prev = 1'b0;
    int   cnt = 0;
    exp_t e;
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
      if (bus.wb_cyc_o === 1'b1 && !cyc_prev) begin
        cyc_starts++;
        cyc_len = 1;
        if (sb.size() == 0) chk("unexpected_cycle", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("bus_adr", bus.wb_adr_o, e.adr);
          chk("bus_we", 32'(bus.wb_we_o), 32'(e.we));
          chk("bus_sel", 32'(bus.wb_sel_o), 32'hF);
          if (e.we) chk("bus_dat", bus.wb_dat_o, e.dat);
        end
      end else if (bus.wb_cyc_o === 1'b1) cyc_len++;
      cyc_prev = (bus.wb_cyc_o === 1'b1);

      if (reset || bus.wb_ack_i) begin
        bus.wb_ack_i = 1'b0;
        cnt = 0;
      end else if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1) begin
        cnt++;
        if (cnt == ack_delay) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = slave_rdata;
        end
      end else cnt = 0;
    end
  end

  // Host side of one frame; tx is left-justified, rx collects bits 48..79.
  task automatic spi_xfer(input logic [79:0] tx, input int nbits, input bit is_rd,
                          input bit keep_cs, output logic [31:0] rx, output int miso_bad);
    rx = '0;
    miso_bad = 0;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[79-i];
      repeat (HALF) @(negedge clk);
      if (!is_rd || i < 48) begin
        if (spi_miso !== 1'b0) miso_bad++;
      end else rx = {rx[30:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    if (!keep_cs) begin
      spi_cs_n = 1'b1;
      repeat (2*HALF) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rx;
    int bad, starts0, errs0;
    bit done;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    chk("rst_busy_err_miso", {29'd0, busy, err, spi_miso}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write, slave acks after 3 clk
    starts0 = cyc_starts; errs0 = err_cnt; ack_delay = 3;
    sb.push_back('{adr: 32'h4000_0000, dat: 32'h0000_00A5, we: 1'b1});
    spi_xfer({8'h80, 32'h4000_0000, 32'h0000_00A5, 8'h00}, 72, 1'b0, 1'b0, rx, bad);
    repeat (10) @(negedge clk);
    chk("wr_cycles", 32'(cyc_starts - starts0), 32'd1);
    chk("wr_cyc_len", 32'(cyc_len), 32'd3);
    chk("wr_err", 32'(err_cnt - errs0), 32'd0);
    chk("wr_miso_zero", 32'(bad), 32'd0);

    // Read, slave returns 0x12345678 after 5 clk
    starts0 = cyc_starts; errs0 = err_cnt; ack_delay = 5; slave_rdata = 32'h1234_5678;
    sb.push_back('{adr: 32'h0000_0010, dat: 32'h0, we: 1'b0});
    spi_xfer({8'h00, 32'h0000_0010, 40'h0}, 80, 1'b1, 1'b0, rx, bad);
    chk("rd_data", rx, 32'h1234_5678);
    chk("rd_miso_idle_zero", 32'(bad), 32'd0);
    chk("rd_cycles", 32'(cyc_starts - starts0), 32'd1);
    chk("rd_cyc_len", 32'(cyc_len), 32'd5);
    chk("rd_err", 32'(err_cnt - errs0), 32'd0);

    // Read timeout: slave never acks
    starts0 = cyc_starts; errs0 = err_cnt; ack_delay = -1; slave_rdata = 32'h0BAD_0BAD;
    sb.push_back('{adr: 32'h0000_0020, dat: 32'h0, we: 1'b0});
    spi_xfer({8'h00, 32'h0000_0020, 40'h0}, 80, 1'b1, 1'b0, rx, bad);
    chk("tmo_data", rx, 32'hFFFF_FFFF);
    chk("tmo_cyc_len", 32'(cyc_len), 32'd64);
    chk("tmo_err_pulses", 32'(err_cnt - errs0), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Abort after 20 address bits, then a normal write
    starts0 = cyc_starts; ack_delay = 2;
    spi_xfer({8'h80, 32'h4000_0008, 32'h5555_5555, 8'h00}, 28, 1'b0, 1'b0, rx, bad);
    repeat (20) @(negedge clk);
    chk("abort_no_cycle", 32'(cyc_starts - starts0), 32'd0);
    chk("abort_idle", 32'(dut.state), 32'(ST_IDLE));
    sb.push_back('{adr: 32'h4000_0004, dat: 32'hDEAD_BEEF, we: 1'b1});
    spi_xfer({8'h80, 32'h4000_0004, 32'hDEAD_BEEF, 8'h00}, 72, 1'b0, 1'b0, rx, bad);
    repeat (10) @(negedge clk);
    chk("post_abort_cycles", 32'(cyc_starts - starts0), 32'd1);
    chk("post_abort_cyc_len", 32'(cyc_len), 32'd2);

    // Reject: second frame starts while the first write is still waiting.
    // The slave holds off 200 clk, so the first cycle ends by timeout
    // (one err) and the rejection adds a second err.
    starts0 = cyc_starts; errs0 = err_cnt; ack_delay = 200;
    sb.push_back('{adr: 32'h0000_0030, dat: 32'h0000_0011, we: 1'b1});
    spi_xfer({8'h80, 32'h0000_0030, 32'h0000_0011, 8'h00}, 72, 1'b0, 1'b0, rx, bad);
    chk("rej_busy_before", 32'(busy), 32'd1);
    spi_xfer({8'h80, 32'h0000_0034, 32'h0000_0022, 8'h00}, 72, 1'b0, 1'b1, rx, bad);
    chk("rej_state_done", 32'(dut.state), 32'(ST_DONE));
    spi_cs_n = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus.wb_cyc_o === 1'b0) done = 1'b1;
    end
    chk("rej_cycle_ended", 32'(done), 32'd1);
    repeat (10) @(negedge clk);
    chk("rej_state_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("rej_cycles", 32'(cyc_starts - starts0), 32'd1);
    chk("rej_err_pulses", 32'(err_cnt - errs0), 32'd2);

    // Reset while cyc is high
    ack_delay = -1;
    sb.push_back('{adr: 32'h0000_0040, dat: 32'hCAFE_0001, we: 1'b1});
    spi_xfer({8'h80, 32'h0000_0040, 32'hCAFE_0001, 8'h00}, 72, 1'b0, 1'b0, rx, bad);
    chk("rst_mid_cyc_before", 32'(bus.wb_cyc_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_mid_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_mid_busy_miso", {30'd0, busy, spi_miso}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
